// File: rtl/led_matrix_pkg.sv
// Shared scan FSM state and counter-width helpers for the LED matrix scanner.
package led_matrix_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int row_w(input int n_rows);
    return cnt_w(n_rows);
  endfunction

  function automatic int slot_w(input int scan_div);
    return cnt_w(scan_div);
  endfunction

endpackage

// File: rtl/led_scan_timer.sv
// Slot/row counters for the matrix scan; exposes next-cycle counts so the top can register outputs with no lag.
// FRAME_SYNC and the wrap strobe refer to the first cycle of row 0's slot; no backpressure.
module led_scan_timer
  import led_matrix_pkg::*;
#(
  parameter int N_ROWS   = 8,
  parameter int SCAN_DIV = 4
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  output logic [slot_w(SCAN_DIV)-1:0] slot_nxt,
  output logic [row_w(N_ROWS)-1:0]    row_nxt,
  output logic                        wrap_nxt,
  output logic                        frame_sync
);

  localparam int SW = slot_w(SCAN_DIV);
  localparam int RW = row_w(N_ROWS);

  logic          started;
  logic [SW-1:0] slot_q;
  logic [RW-1:0] row_q;

  // The first edge after reset enters slot 0 of row 0 without advancing,
  // so that slot starts with a FRAME_SYNC pulse like every later frame.
  always_comb begin
    slot_nxt = slot_q;
    row_nxt  = row_q;
    wrap_nxt = 1'b0;
    if (started) begin
      if (slot_q == SW'(SCAN_DIV - 1)) begin
        slot_nxt = '0;
        if (row_q == RW'(N_ROWS - 1)) begin
          row_nxt  = '0;
          wrap_nxt = 1'b1;
        end else begin
          row_nxt = row_q + 1'b1;
        end
      end else begin
        slot_nxt = slot_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      started    <= 1'b0;
      slot_q     <= '0;
      row_q      <= '0;
      frame_sync <= 1'b0;
    end else begin
      started    <= 1'b1;
      slot_q     <= slot_nxt;
      row_q      <= row_nxt;
      frame_sync <= wrap_nxt || !started;
    end
  end

endmodule

// File: rtl/led_matrix_scanner.sv
// Double-buffered bicolour LED matrix scanner; all pins registered, in step with the scan state (no extra latency).
// Writes always accepted into the back buffer; swaps wait for the frame wrap. LED_PWM_DIM_EN adds BRIGHT column dimming.
module led_matrix_scanner
  import led_matrix_pkg::*;
#(
  parameter int N_ROWS       = 8,
  parameter int N_COLS       = 8,
  parameter int SCAN_DIV     = 4,
  parameter int BLANK_CYCLES = 1,
  parameter int BRIGHT_W     = 3
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      WR_EN,
  input  logic [row_w(N_ROWS)-1:0]  WR_ROW,
  input  logic [N_COLS-1:0]         WR_RED,
  input  logic [N_COLS-1:0]         WR_GREEN,
  input  logic                      SWAP_REQ,
  output logic                      SWAP_ACK,
`ifdef LED_PWM_DIM_EN
  input  logic [BRIGHT_W-1:0]       BRIGHT,
`endif
  output logic [N_ROWS-1:0]         ROW,
  output logic [N_COLS-1:0]         COL_RED,
  output logic [N_COLS-1:0]         COL_GREEN,
  output logic                      FRAME_SYNC
);

  localparam int SW = slot_w(SCAN_DIV);
  localparam int RW = row_w(N_ROWS);

  logic [SW-1:0]     slot_nxt;
  logic [RW-1:0]     row_nxt;
  logic              wrap_nxt;
  scan_state_e       state_q, state_nxt;
  logic              front_q, front_nxt, pend_q, swap_nxt, col_on;
  logic [N_ROWS-1:0] row_d;
  logic [N_COLS-1:0] red_d, green_d;
  logic [N_COLS-1:0] buf_red   [2][N_ROWS];
  logic [N_COLS-1:0] buf_green [2][N_ROWS];

  led_scan_timer #(
    .N_ROWS   (N_ROWS),
    .SCAN_DIV (SCAN_DIV)
  ) u_timer (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .slot_nxt   (slot_nxt),
    .row_nxt    (row_nxt),
    .wrap_nxt   (wrap_nxt),
    .frame_sync (FRAME_SYNC)
  );

  // Everything below is decoded from next-cycle counts so the registered pins
  // line up with the counter state of the same cycle.
  always_comb begin
    swap_nxt  = wrap_nxt && (pend_q || SWAP_REQ);
    front_nxt = front_q ^ swap_nxt;
    state_nxt = state_q;
    case (state_q)
      BLANK:   if (slot_nxt == SW'(BLANK_CYCLES)) state_nxt = SHOW;
      SHOW:    if (BLANK_CYCLES > 0 && slot_nxt == '0) state_nxt = BLANK;
      default: state_nxt = BLANK;
    endcase
`ifdef LED_PWM_DIM_EN
    col_on = (BRIGHT == {BRIGHT_W{1'b1}}) ||
             ((int'(slot_nxt) - BLANK_CYCLES) <
              (int'(BRIGHT) * (SCAN_DIV - BLANK_CYCLES)) / (2 ** BRIGHT_W));
`else
    col_on = 1'b1;
`endif
    row_d   = '1;
    red_d   = '0;
    green_d = '0;
    if (state_nxt == SHOW) begin
      row_d = ~(N_ROWS'(1) << row_nxt);
      if (col_on) begin
        red_d   = buf_red[front_nxt][row_nxt];
        green_d = buf_green[front_nxt][row_nxt];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= BLANK;
      front_q   <= 1'b0;
      pend_q    <= 1'b0;
      SWAP_ACK  <= 1'b0;
      ROW       <= '1;
      COL_RED   <= '0;
      COL_GREEN <= '0;
    end else begin
      state_q   <= state_nxt;
      front_q   <= front_nxt;
      pend_q    <= swap_nxt ? 1'b0 : (pend_q | SWAP_REQ);
      SWAP_ACK  <= swap_nxt;
      ROW       <= row_d;
      COL_RED   <= red_d;
      COL_GREEN <= green_d;
    end
  end

  // A write sampled on the swap edge still targets the pre-swap back buffer.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int r = 0; r < N_ROWS; r++) begin
        buf_red[0][r]   <= '0;
        buf_red[1][r]   <= '0;
        buf_green[0][r] <= '0;
        buf_green[1][r] <= '0;
      end
    end else if (WR_EN && int'(WR_ROW) < N_ROWS) begin
      buf_red[~front_q][WR_ROW]   <= WR_RED;
      buf_green[~front_q][WR_ROW] <= WR_GREEN;
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed/randomised bench for led_matrix_scanner against a cycle-count based reference model.
`timescale 1ns/1ps
module tb_led_matrix_scanner;

  localparam int NR = 8;
  localparam int NC = 8;
  localparam int BW = 3;
`ifdef LED_PWM_DIM_EN
  localparam int SD = 10;
  localparam int BL = 2;
`else
  localparam int SD = 4;
  localparam int BL = 1;
`endif
  localparam int FRAME = NR * SD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic          swap_req = 1'b0;
  logic [2:0]    wr_row = '0;
  logic [NC-1:0] wr_red = '0;
  logic [NC-1:0] wr_green = '0;
  logic [BW-1:0] bright = '1;
  logic          swap_ack, frame_sync;
  logic [NR-1:0] row;
  logic [NC-1:0] col_red, col_green;

  int checks = 0;
  int errors = 0;

  // Reference model: scan position is pure arithmetic on the cycle index t.
  int            t;
  bit            fr, pend;
  logic [NC-1:0] m_red   [2][NR];
  logic [NC-1:0] m_green [2][NR];
  logic [NR-1:0] e_row;
  logic [NC-1:0] e_red, e_green;
  logic          e_fs, e_ack;

  always #5 clk = ~clk;

  led_matrix_scanner #(
    .N_ROWS(NR), .N_COLS(NC), .SCAN_DIV(SD), .BLANK_CYCLES(BL), .BRIGHT_W(BW)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .WR_EN(wr_en), .WR_ROW(wr_row),
    .WR_RED(wr_red), .WR_GREEN(wr_green), .SWAP_REQ(swap_req), .SWAP_ACK(swap_ack),
`ifdef LED_PWM_DIM_EN
    .BRIGHT(bright),
`endif
    .ROW(row), .COL_RED(col_red), .COL_GREEN(col_green), .FRAME_SYNC(frame_sync)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  function automatic bit col_lit(input int slot);
`ifdef LED_PWM_DIM_EN
    return (bright == '1) || ((slot - BL) < (int'(bright) * (SD - BL)) / (2 ** BW));
`else
    return (slot >= 0);
`endif
  endfunction

  task automatic model_reset();
    t = -1; fr = 0; pend = 0;
    for (int r = 0; r < NR; r++) begin
      m_red[0][r] = '0; m_red[1][r] = '0; m_green[0][r] = '0; m_green[1][r] = '0;
    end
    e_row = '1; e_red = '0; e_green = '0; e_fs = 0; e_ack = 0;
  endtask

  task automatic model_edge();
    int slot, r, tgt;
    bit wrap;
    t++;
    slot = t % SD;
    r    = (t / SD) % NR;
    wrap = (t > 0) && (t % FRAME == 0);
    tgt  = fr ? 0 : 1;
    e_ack = 0;
    if (wrap && (pend || swap_req)) begin
      fr = !fr; pend = 0; e_ack = 1;
    end else if (swap_req) begin
      pend = 1;
    end
    e_fs = (t % FRAME == 0);
    e_row = '1; e_red = '0; e_green = '0;
    if (slot >= BL) begin
      e_row = ~(NR'(1) << r);
      if (col_lit(slot)) begin
        e_red = m_red[fr][r]; e_green = m_green[fr][r];
      end
    end
    if (wr_en) begin
      m_red[tgt][wr_row] = wr_red; m_green[tgt][wr_row] = wr_green;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("ROW", row, e_row);
    chk("COL_RED", col_red, e_red);
    chk("COL_GREEN", col_green, e_green);
    chk("FRAME_SYNC", frame_sync, e_fs);
    chk("SWAP_ACK", swap_ack, e_ack);
  endtask

  task automatic idle();
    wr_en = 0; swap_req = 0;
  endtask

  task automatic wait_fs();
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (frame_sync === 1'b1) break;
    end
    chk("fs_seen", frame_sync, 1);
  endtask

  initial begin
    int acks, lit;
    model_reset();
    rst_n = 0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ROW", row, 8'hFF);
      chk("rst_COL", {col_red, col_green}, 0);
      chk("rst_pulses", {frame_sync, swap_ack}, 0);
    end
    rst_n = 1;

    // Reset release and free-running scan order
    step();
    step();
    chk("first_show", row, 8'hFE);
    repeat (2 * FRAME) step();

    // Writes without a swap request never reach the pins
    lit = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      wr_en = 1'($urandom_range(0, 1)); wr_row = 3'($urandom);
      wr_red = 8'($urandom); wr_green = 8'($urandom);
      step();
      lit = lit | int'(col_red) | int'(col_green);
    end
    idle();
    chk("no_early_swap", lit, 0);

    // Row 3 red pattern, swap requested mid-frame
    wr_en = 1; wr_row = 3; wr_red = 8'h0E; wr_green = 8'h00;
    step();
    idle();
    repeat (5) step();
    swap_req = 1;
    step();
    swap_req = 0;
    wait_fs();
    chk("ack_with_fs", swap_ack, 1);
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (row === 8'hF7) break;
    end
    chk("row3_red", col_red, 8'h0E);

    // Three requests in one frame collapse to a single swap
    wait_fs();
    acks = 0;
    for (int k = 1; k <= 2 * FRAME; k++) begin
      swap_req = (k == 3 || k == 10 || k == 20);
      step();
      acks += int'(swap_ack);
    end
    idle();
    chk("one_ack", acks, 1);

    // Request and write sampled on the wrap edge itself
    wait_fs();
    repeat (FRAME - 1) step();
    swap_req = 1; wr_en = 1; wr_row = 3'($urandom); wr_red = 8'($urandom); wr_green = 8'($urandom);
    step();
    idle();
    chk("ack_same_edge", swap_ack, 1);
    acks = 0;
    repeat (FRAME) begin
      step();
      acks += int'(swap_ack);
    end
    chk("no_leftover_pend", acks, 0);

    // Random mix of writes and occasional swaps
    for (int i = 0; i < 12 * FRAME; i++) begin
      wr_en = 1'($urandom_range(0, 1)); wr_row = 3'($urandom);
      wr_red = 8'($urandom); wr_green = 8'($urandom);
      swap_req = ($urandom_range(0, 19) == 0);
      step();
    end
    idle();

`ifdef LED_PWM_DIM_EN
    for (int r = 0; r < NR; r++) begin
      wr_en = 1; wr_row = 3'(r); wr_red = 8'hFF; wr_green = 8'h00;
      step();
    end
    idle();
    swap_req = 1;
    step();
    swap_req = 0;
    wait_fs();
    bright = 3'd4;
    lit = 0;
    repeat (FRAME) begin
      step();
      lit += int'(col_red != 0);
    end
    chk("pwm_half", lit, NR * 4);
    bright = 3'd0;
    lit = 0;
    acks = 0;
    repeat (FRAME) begin
      step();
      lit += int'(col_red != 0);
      acks += int'(row != 8'hFF);
    end
    chk("pwm_off", lit, 0);
    chk("pwm_row_timing", acks, NR * (SD - BL));
    bright = '1;
`endif

    // Asynchronous reset in the SHOW phase of row 5
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (t % FRAME == 5 * SD + BL + 1) break;
    end
    chk("row5_show", row, 8'hDF);
    swap_req = 1;
    #2 rst_n = 0;
    #1;
    chk("async_ROW", row, 8'hFF);
    chk("async_COL", {col_red, col_green}, 0);
    chk("async_pulses", {frame_sync, swap_ack}, 0);
    swap_req = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    step();
    chk("restart_blank", row, 8'hFF);
    chk("restart_fs", frame_sync, 1);
    repeat (FRAME) step();
    swap_req = 1;
    step();
    swap_req = 0;
    repeat (2 * FRAME) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
